// File: rtl/pim_cfu_ctrl.sv
// pim_cfu_ctrl: CFU-facing command sequencer for pim_model.
// Accepts one CFU command at a time and turns it into a pim_model write,
// read or MAC transaction. A 256-bit row-wordline shadow mask is loaded
// 32 bits per command and drives pim_rwl continuously.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready            CFU command handshake
//   cmd_funct, cmd_in0, cmd_in1    function id and operands
//   rsp_valid/rsp_ready            CFU response handshake
//   rsp_out, rsp_err               response data and error flag
//   pim_d, pim_addr, pim_rwl       pim_model data, address, wordline mask
//   pim_w_en, pim_p_en             pim_model operation encoding
//   pim_cmd_valid/pim_cmd_ready    pim_model command handshake
//   pim_rsp_valid/pim_rsp_ready    pim_model response handshake
//   pim_q, pim_mac                 pim_model read data and MAC result
//
// Optional feature macro: PIM_CFU_PERF_EN adds write/read/MAC/busy
// counters readable through function 7 (PERF_READ).
module pim_cfu_ctrl #(
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned AWIDTH  = 8,
    parameter int unsigned PWIDTH  = 32,
    parameter int unsigned PDEPTH  = 256,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_funct,
    input  logic [DWIDTH-1:0] cmd_in0,
    input  logic [DWIDTH-1:0] cmd_in1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_out,
    output logic              rsp_err,
    output logic [PWIDTH-1:0] pim_d,
    output logic [AWIDTH-1:0] pim_addr,
    output logic [PDEPTH-1:0] pim_rwl,
    output logic              pim_w_en,
    output logic              pim_p_en,
    output logic              pim_cmd_valid,
    input  logic              pim_cmd_ready,
    input  logic              pim_rsp_valid,
    output logic              pim_rsp_ready,
    input  logic [PWIDTH-1:0] pim_q,
    input  logic [DWIDTH-1:0] pim_mac
);

    localparam int unsigned NWORDS = PDEPTH / 32;
    localparam int unsigned TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] F_WRITE     = 3'd0;
    localparam logic [2:0] F_READ      = 3'd1;
    localparam logic [2:0] F_RWL_LOAD  = 3'd2;
    localparam logic [2:0] F_RWL_CLEAR = 3'd3;
    localparam logic [2:0] F_MAC       = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [2:0]        funct_q, funct_n;
    logic [TW-1:0]     tmo_cnt, tmo_cnt_n;
    logic [31:0]       rwl_k;

    logic              cmd_ready_n;
    logic              rsp_valid_n;
    logic [DWIDTH-1:0] rsp_out_n;
    logic              rsp_err_n;
    logic [PWIDTH-1:0] pim_d_n;
    logic [AWIDTH-1:0] pim_addr_n;
    logic [PDEPTH-1:0] pim_rwl_n;
    logic              pim_w_en_n;
    logic              pim_p_en_n;
    logic              pim_cmd_valid_n;
    logic              pim_rsp_ready_n;

    // Only the low operand bits select address / mask word.
    logic unused_ok;
    assign unused_ok = ^cmd_in0;

    // Mask word index wraps when the mask holds fewer than eight words.
    assign rwl_k = 32'(cmd_in0[2:0]) % 32'(NWORDS);

`ifdef PIM_CFU_PERF_EN
    localparam logic [2:0] F_PERF = 3'd7;

    logic [31:0] perf_wr, perf_rd, perf_mac, perf_busy;
    logic [31:0] perf_val;
    logic        perf_clr;

    // Counter selected by in0[1:0] for PERF_READ.
    always_comb begin
        perf_val = perf_wr;
        case (cmd_in0[1:0])
            2'd0:    perf_val = perf_wr;
            2'd1:    perf_val = perf_rd;
            2'd2:    perf_val = perf_mac;
            default: perf_val = perf_busy;
        endcase
    end

    // Clear takes effect on the accept edge, after the value is captured.
    assign perf_clr = cmd_valid && cmd_ready && (cmd_funct == F_PERF) && cmd_in0[2];

    // Issue and busy-cycle counters.
    always_ff @(posedge clk) begin
        if (reset || perf_clr) begin
            perf_wr   <= '0;
            perf_rd   <= '0;
            perf_mac  <= '0;
            perf_busy <= '0;
        end else begin
            if (state == S_ISSUE && pim_cmd_ready) begin
                if (funct_q == F_WRITE) perf_wr  <= perf_wr + 32'd1;
                if (funct_q == F_READ)  perf_rd  <= perf_rd + 32'd1;
                if (funct_q == F_MAC)   perf_mac <= perf_mac + 32'd1;
            end
            if (state != S_IDLE) perf_busy <= perf_busy + 32'd1;
        end
    end
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n         = state;
        funct_n         = funct_q;
        tmo_cnt_n       = tmo_cnt;
        cmd_ready_n     = cmd_ready;
        rsp_valid_n     = rsp_valid;
        rsp_out_n       = rsp_out;
        rsp_err_n       = rsp_err;
        pim_d_n         = pim_d;
        pim_addr_n      = pim_addr;
        pim_rwl_n       = pim_rwl;
        pim_w_en_n      = pim_w_en;
        pim_p_en_n      = pim_p_en;
        pim_cmd_valid_n = pim_cmd_valid;
        pim_rsp_ready_n = pim_rsp_ready;

        case (state)
            S_IDLE: begin
                // cmd_ready is 0 for the first cycle out of reset.
                cmd_ready_n = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    funct_n     = cmd_funct;
                    cmd_ready_n = 1'b0;
                    rsp_err_n   = 1'b0;
                    case (cmd_funct)
                        F_WRITE, F_READ, F_MAC: begin
                            pim_d_n         = PWIDTH'(cmd_in1);
                            pim_addr_n      = cmd_in0[AWIDTH-1:0];
                            pim_w_en_n      = (cmd_funct == F_WRITE);
                            pim_p_en_n      = (cmd_funct == F_MAC);
                            pim_cmd_valid_n = 1'b1;
                            state_n         = S_ISSUE;
                        end
                        F_RWL_LOAD: begin
                            rsp_out_n = '0;
                            for (int unsigned i = 0; i < NWORDS; i++) begin
                                if (rwl_k == i) begin
                                    rsp_out_n             = DWIDTH'(pim_rwl[32*i +: 32]);
                                    pim_rwl_n[32*i +: 32] = 32'(cmd_in1);
                                end
                            end
                            rsp_valid_n = 1'b1;
                            state_n     = S_RESP;
                        end
                        F_RWL_CLEAR: begin
                            pim_rwl_n   = '0;
                            rsp_out_n   = '0;
                            rsp_valid_n = 1'b1;
                            state_n     = S_RESP;
                        end
`ifdef PIM_CFU_PERF_EN
                        F_PERF: begin
                            rsp_out_n   = DWIDTH'(perf_val);
                            rsp_valid_n = 1'b1;
                            state_n     = S_RESP;
                        end
`endif
                        default: begin
                            rsp_out_n   = '1;
                            rsp_err_n   = 1'b1;
                            rsp_valid_n = 1'b1;
                            state_n     = S_RESP;
                        end
                    endcase
                end
            end

            S_ISSUE: begin
                if (pim_cmd_ready) begin
                    pim_cmd_valid_n = 1'b0;
                    pim_w_en_n      = 1'b0;
                    pim_p_en_n      = 1'b0;
                    pim_rsp_ready_n = 1'b1;
                    tmo_cnt_n       = '0;
                    state_n         = S_WAIT;
                end
            end

            S_WAIT: begin
                if (pim_rsp_valid) begin
                    case (funct_q)
                        F_READ:  rsp_out_n = DWIDTH'(pim_q);
                        F_MAC:   rsp_out_n = pim_mac;
                        default: rsp_out_n = '0;
                    endcase
                    rsp_err_n       = 1'b0;
                    rsp_valid_n     = 1'b1;
                    pim_rsp_ready_n = 1'b0;
                    state_n         = S_RESP;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    rsp_out_n       = '1;
                    rsp_err_n       = 1'b1;
                    rsp_valid_n     = 1'b1;
                    pim_rsp_ready_n = 1'b0;
                    state_n         = S_RESP;
                end else begin
                    tmo_cnt_n = tmo_cnt + TW'(1);
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    cmd_ready_n = 1'b1;
                    state_n     = S_IDLE;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            funct_q       <= '0;
            tmo_cnt       <= '0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_out       <= '0;
            rsp_err       <= 1'b0;
            pim_d         <= '0;
            pim_addr      <= '0;
            pim_rwl       <= '0;
            pim_w_en      <= 1'b0;
            pim_p_en      <= 1'b0;
            pim_cmd_valid <= 1'b0;
            pim_rsp_ready <= 1'b0;
        end else begin
            state         <= state_n;
            funct_q       <= funct_n;
            tmo_cnt       <= tmo_cnt_n;
            cmd_ready     <= cmd_ready_n;
            rsp_valid     <= rsp_valid_n;
            rsp_out       <= rsp_out_n;
            rsp_err       <= rsp_err_n;
            pim_d         <= pim_d_n;
            pim_addr      <= pim_addr_n;
            pim_rwl       <= pim_rwl_n;
            pim_w_en      <= pim_w_en_n;
            pim_p_en      <= pim_p_en_n;
            pim_cmd_valid <= pim_cmd_valid_n;
            pim_rsp_ready <= pim_rsp_ready_n;
        end
    end

endmodule

// File: tb/tb_pim_cfu_ctrl.sv
// tb_pim_cfu_ctrl: table-driven bench for pim_cfu_ctrl with a small
// configurable pim_model responder, plus hand-written sequences for
// back-to-back handshakes and reset in the middle of a MAC.
module tb_pim_cfu_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_funct = 3'd0;
    logic [31:0]  cmd_in0 = 32'd0;
    logic [31:0]  cmd_in1 = 32'd0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [31:0]  rsp_out;
    logic         rsp_err;
    logic [31:0]  pim_d;
    logic [7:0]   pim_addr;
    logic [255:0] pim_rwl;
    logic         pim_w_en;
    logic         pim_p_en;
    logic         pim_cmd_valid;
    logic         pim_cmd_ready = 1'b0;
    logic         pim_rsp_valid = 1'b0;
    logic         pim_rsp_ready;
    logic [31:0]  pim_q = 32'd0;
    logic [31:0]  pim_mac = 32'd0;

    int total = 0;
    int bad   = 0;

    // Responder configuration.
    int cfg_rdy    = 0;
    int cfg_rspd   = 0;
    bit cfg_rsp_en = 1'b1;
    int iss_cnt    = 0;
    int w_cnt      = 0;

    always #5 clk = ~clk;

    pim_cfu_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_funct     (cmd_funct),
        .cmd_in0       (cmd_in0),
        .cmd_in1       (cmd_in1),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_out       (rsp_out),
        .rsp_err       (rsp_err),
        .pim_d         (pim_d),
        .pim_addr      (pim_addr),
        .pim_rwl       (pim_rwl),
        .pim_w_en      (pim_w_en),
        .pim_p_en      (pim_p_en),
        .pim_cmd_valid (pim_cmd_valid),
        .pim_cmd_ready (pim_cmd_ready),
        .pim_rsp_valid (pim_rsp_valid),
        .pim_rsp_ready (pim_rsp_ready),
        .pim_q         (pim_q),
        .pim_mac       (pim_mac)
    );

    // pim_model stand-in: accepts after cfg_rdy ISSUE cycles, answers
    // after cfg_rspd WAIT cycles (or never when cfg_rsp_en is 0).
    always @(posedge clk) begin
        #1;
        if (reset) begin
            pim_cmd_ready = 1'b0;
            pim_rsp_valid = 1'b0;
            iss_cnt       = 0;
            w_cnt         = 0;
        end else begin
            if (pim_cmd_valid) begin
                pim_cmd_ready = (iss_cnt >= cfg_rdy);
                iss_cnt++;
            end else begin
                pim_cmd_ready = 1'b0;
                iss_cnt       = 0;
            end
            if (pim_rsp_ready) begin
                pim_rsp_valid = cfg_rsp_en && (w_cnt >= cfg_rspd);
                w_cnt++;
            end else begin
                pim_rsp_valid = 1'b0;
                w_cnt         = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Issue one command, observe the PIM side until the response, hold the
    // response for 'hold' cycles, then accept it.
    task automatic run_cmd(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input int hold, output logic [31:0] out, output logic err,
                           output int lat, output int n_iss, output int n_wen,
                           output int n_pen, output logic [7:0] ad, output logic [31:0] dd,
                           output logic stable);
        int g;
        g = 0;
        while (!cmd_ready && g < 20) begin
            step();
            g++;
        end
        cmd_valid = 1'b1;
        cmd_funct = f;
        cmd_in0   = a;
        cmd_in1   = b;
        step();
        cmd_valid = 1'b0;
        cmd_funct = 3'd0;
        cmd_in0   = 32'd0;
        cmd_in1   = 32'd0;
        lat = 1; n_iss = 0; n_wen = 0; n_pen = 0; ad = '0; dd = '0; stable = 1'b1;
        while (!rsp_valid && lat < 300) begin
            if (cmd_ready) stable = 1'b0;
            if (pim_cmd_valid) begin
                if (n_iss == 0) begin
                    ad = pim_addr;
                    dd = pim_d;
                end else if (pim_addr != ad || pim_d != dd) begin
                    stable = 1'b0;
                end
                n_iss++;
            end
            if (pim_w_en) n_wen++;
            if (pim_p_en) n_pen++;
            step();
            lat++;
        end
        out = rsp_out;
        err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            step();
            if (!rsp_valid || rsp_out != out || rsp_err != err || cmd_ready) stable = 1'b0;
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        if (rsp_valid || !cmd_ready) stable = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          rdy;
        int          rspd;
        bit          rsp_en;
        int          hold;
        logic [31:0] q;
        logic [31:0] mac;
        logic [31:0] eout;
        logic        eerr;
        int          elat;
        int          eiss;
        int          ewen;
        int          epen;
    } vec_t;

    localparam int NV = 20;
    vec_t vt[NV];

    initial begin
        logic [31:0]  o;
        logic         e;
        int           lat, niss, nwen, npen, g;
        logic [7:0]   ad;
        logic [31:0]  dd;
        logic         st;
        logic [255:0] exp_rwl;
        logic         saw_rsp;

        //          f     a             b             rdy rspd en hold q             mac           eout          err lat iss wen pen
        vt[0]  = '{3'd0, 32'h10,       32'hA5A5_0001, 0, 1, 1'b1, 0, 32'h0,        32'h0,        32'h0,        1'b0, 4, 1, 1, 0};
        vt[1]  = '{3'd1, 32'h10,       32'h0,         0, 0, 1'b1, 0, 32'hA5A5_0001, 32'h0,       32'hA5A5_0001, 1'b0, 3, 1, 0, 0};
        vt[2]  = '{3'd3, 32'h0,        32'h0,         0, 0, 1'b1, 0, 32'h0,        32'h0,        32'h0,        1'b0, 1, 0, 0, 0};
        for (int k = 0; k < 8; k++)
            vt[3+k] = '{3'd2, 32'(k), 32'h1 << k,     0, 0, 1'b1, 0, 32'h0,        32'h0,        32'h0,        1'b0, 1, 0, 0, 0};
        vt[11] = '{3'd4, 32'h0,        32'h0,         0, 0, 1'b1, 0, 32'h0,        32'h123,      32'h123,      1'b0, 3, 1, 0, 1};
        vt[12] = '{3'd2, 32'h3,        32'hDEAD_0000, 0, 0, 1'b1, 0, 32'h0,        32'h0,        32'h8,        1'b0, 1, 0, 0, 0};
        vt[13] = '{3'd2, 32'hB,        32'h8,         0, 0, 1'b1, 0, 32'h0,        32'h0,        32'hDEAD_0000, 1'b0, 1, 0, 0, 0};
        vt[14] = '{3'd5, 32'h0,        32'h0,         0, 0, 1'b1, 0, 32'h0,        32'h0,        32'hFFFF_FFFF, 1'b1, 1, 0, 0, 0};
        vt[15] = '{3'd6, 32'h1,        32'h2,         0, 0, 1'b1, 0, 32'h0,        32'h0,        32'hFFFF_FFFF, 1'b1, 1, 0, 0, 0};
        vt[16] = '{3'd7, 32'h7,        32'h0,         0, 0, 1'b1, 0, 32'h0,        32'h0,        32'hFFFF_FFFF, 1'b1, 1, 0, 0, 0};
        vt[17] = '{3'd1, 32'h22,       32'h0,         0, 0, 1'b0, 0, 32'h5555_5555, 32'h0,       32'hFFFF_FFFF, 1'b1, 66, 1, 0, 0};
        vt[18] = '{3'd1, 32'h1FF,      32'h0,         5, 0, 1'b1, 3, 32'h1234_5678, 32'h0,       32'h1234_5678, 1'b0, 8, 6, 0, 0};
        vt[19] = '{3'd0, 32'h3,        32'h0BAD_F00D, 2, 3, 1'b1, 1, 32'h0,        32'h0,        32'h0,        1'b0, 8, 3, 3, 0};

        // Reset state.
        repeat (3) step();
        chk("rst_ctrl", {cmd_ready, rsp_valid, rsp_err, pim_cmd_valid, pim_rsp_ready, pim_w_en, pim_p_en}, '0);
        chk("rst_rsp_out", rsp_out, '0);
        chk("rst_rwl", pim_rwl, '0);
        chk("rst_pim_ad", {pim_addr, pim_d}, '0);
        reset = 1'b0;
        step();
        chk("idle_ready", cmd_ready, 1);

        for (int i = 0; i < NV; i++) begin
            cfg_rdy    = vt[i].rdy;
            cfg_rspd   = vt[i].rspd;
            cfg_rsp_en = vt[i].rsp_en;
            pim_q      = vt[i].q;
            pim_mac    = vt[i].mac;
            run_cmd(vt[i].f, vt[i].a, vt[i].b, vt[i].hold, o, e, lat, niss, nwen, npen, ad, dd, st);
            chk($sformatf("v%0d_out", i), o, vt[i].eout);
            chk($sformatf("v%0d_err", i), e, vt[i].eerr);
            chk($sformatf("v%0d_lat", i), lat, vt[i].elat);
            chk($sformatf("v%0d_issue_cycles", i), niss, vt[i].eiss);
            chk($sformatf("v%0d_w_en_cycles", i), nwen, vt[i].ewen);
            chk($sformatf("v%0d_p_en_cycles", i), npen, vt[i].epen);
            chk($sformatf("v%0d_stable", i), st, 1);
            if (vt[i].f == 3'd0 || vt[i].f == 3'd1)
                chk($sformatf("v%0d_addr", i), ad, vt[i].a[7:0]);
            if (vt[i].f == 3'd0)
                chk($sformatf("v%0d_d", i), dd, vt[i].b);
        end

        // Mask after loading word k with 1<<k: bits 33*k.
        exp_rwl = '0;
        for (int k = 0; k < 8; k++) exp_rwl[33*k] = 1'b1;
        chk("rwl_diag", pim_rwl, exp_rwl);

        // Response accept and a new command in the same cycle.
        cfg_rsp_en = 1'b1;
        cmd_valid  = 1'b1;
        cmd_funct  = 3'd3;
        step();
        chk("b2b_first_rsp", rsp_valid, 1);
        cmd_funct = 3'd5;
        rsp_ready = 1'b1;
        step();
        chk("b2b_gap", {rsp_valid, cmd_ready}, 2'b01);
        rsp_ready = 1'b0;
        step();
        chk("b2b_second", {rsp_valid, rsp_err, pim_cmd_valid}, 3'b110);
        chk("b2b_second_out", rsp_out, 32'hFFFF_FFFF);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("b2b_done", rsp_valid, 0);
        chk("b2b_rwl_clr", pim_rwl, '0);

        // Reset during WAIT of a MAC.
        run_cmd(3'd2, 32'h5, 32'hFFFF_0000, 0, o, e, lat, niss, nwen, npen, ad, dd, st);
        chk("pre_load_old", o, 32'h0);
        exp_rwl = '0;
        exp_rwl[191:160] = 32'hFFFF_0000;
        chk("pre_load_rwl", pim_rwl, exp_rwl);
        cfg_rdy    = 0;
        cfg_rsp_en = 1'b0;
        cmd_valid  = 1'b1;
        cmd_funct  = 3'd4;
        step();
        cmd_valid = 1'b0;
        saw_rsp   = rsp_valid;
        g = 0;
        while (!pim_rsp_ready && g < 20) begin
            step();
            g++;
        end
        chk("mac_in_wait", pim_rsp_ready, 1);
        repeat (2) begin
            step();
            saw_rsp = saw_rsp | rsp_valid;
        end
        reset = 1'b1;
        step();
        chk("mac_no_rsp", saw_rsp | rsp_valid, 0);
        chk("mr_ctrl", {cmd_ready, rsp_valid, rsp_err, pim_cmd_valid, pim_rsp_ready, pim_w_en, pim_p_en}, '0);
        chk("mr_rsp_out", rsp_out, '0);
        chk("mr_rwl", pim_rwl, '0);
        chk("mr_pim_ad", {pim_addr, pim_d}, '0);
        reset      = 1'b0;
        cfg_rsp_en = 1'b1;
        cfg_rspd   = 0;
        pim_q      = 32'hCAFE_BABE;
        step();
        run_cmd(3'd1, 32'h44, 32'h0, 0, o, e, lat, niss, nwen, npen, ad, dd, st);
        chk("post_rst_out", o, 32'hCAFE_BABE);
        chk("post_rst_err", e, 0);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_addr", ad, 8'h44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
